// File: rtl/key_tx_queue.sv
// Keystroke byte FIFO with VT100 cursor-key expansion, pacing a UART via start/busy handshake.
// Optional build macro: NEWLINE_CRLF_EN (CR key expands to CR LF).
//
// state   | meaning
// IDLE    | wait for queued byte and idle transmitter; pop head into txData
// SEND    | txStart asserted for this single cycle
// WAIT_HI | wait for txBusy to rise, give up after ACK_TIMEOUT cycles
// WAIT_LO | wait for transmitter to finish the byte
module key_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     keyValid,
  input  logic [7:0]               keyData,
  input  logic                     keyIsSpecial,
  output logic                     txStart,
  output logic [7:0]               txData,
  input  logic                     txBusy,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic                     keyDropped,
  output logic [7:0]               dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic [CW-1:0]  r_to_cnt;
  logic           r_tx_start;
  logic [7:0]     r_tx_data;
  logic           r_drop;
  logic [7:0]     r_drop_cnt;

  logic [1:0]     w_len;
  logic [7:0]     w_b0;
  logic [7:0]     w_b1;
  logic [7:0]     w_b2;
  logic [LW-1:0]  w_free;
  logic           w_fits;
  logic           w_push;
  logic           w_drop;
  logic           w_pop;

  always_comb begin
    w_len = 2'd0;
    w_b0  = keyData;
    w_b1  = 8'h5B;
    w_b2  = 8'h00;
    if (keyIsSpecial) begin
      w_b0  = 8'h1B;
      w_len = 2'd3;
      case (keyData)
        8'h01:   w_b2 = 8'h41;
        8'h02:   w_b2 = 8'h42;
        8'h03:   w_b2 = 8'h43;
        8'h04:   w_b2 = 8'h44;
        8'h05:   w_b2 = 8'h48;
        8'h06:   w_b2 = 8'h46;
        default: w_len = 2'd0;
      endcase
    end else begin
      w_len = 2'd1;
`ifdef NEWLINE_CRLF_EN
      if (keyData == 8'h0D) begin
        w_len = 2'd2;
        w_b1  = 8'h0A;
      end
`endif
    end
  end

  // Free space is judged on the level before any pop in the same cycle.
  assign w_free = LW'(DEPTH) - r_level;
  assign w_fits = (w_free >= LW'(w_len));
  assign w_push = keyValid && (w_len != 2'd0) && w_fits;
  assign w_drop = keyValid && (w_len != 2'd0) && !w_fits;
  assign w_pop  = (r_state == IDLE) && (r_level != '0) && !txBusy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = SEND;
      SEND:    w_state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (txBusy)                               w_state_nxt = WAIT_LO;
        else if (r_to_cnt == CW'(ACK_TIMEOUT - 1)) w_state_nxt = IDLE;
      end
      WAIT_LO: if (!txBusy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_to_cnt   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_drop     <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_tx_start <= (w_state_nxt == SEND);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (r_state == SEND)                    r_to_cnt <= '0;
      else if (r_state == WAIT_HI && !txBusy) r_to_cnt <= r_to_cnt + CW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(w_len);
      r_level <= r_level + (w_push ? LW'(w_len) : LW'(0)) - (w_pop ? LW'(1) : LW'(0));
      r_drop  <= w_drop;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // All bytes of one key land on the same edge, so a sequence is never split.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_b0;
      if (w_len >= 2'd2) r_mem[r_wr_ptr + AW'(1)] <= w_b1;
      if (w_len == 2'd3) r_mem[r_wr_ptr + AW'(2)] <= w_b2;
    end
  end

  assign txStart    = r_tx_start;
  assign txData     = r_tx_data;
  assign fifoLevel  = r_level;
  assign keyDropped = r_drop;
  assign dropCount  = r_drop_cnt;

endmodule

// File: tb/tb_key_tx_queue.sv
// Directed self-checking bench for key_tx_queue with a simple UART busy model.
module tb_key_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       keyValid = 1'b0;
  logic [7:0] keyData = 8'h00;
  logic       keyIsSpecial = 1'b0;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic [4:0] fifoLevel;
  logic       keyDropped;
  logic [7:0] dropCount;

  logic       model_en = 1'b0;
  logic       force_hi = 1'b0;
  logic       model_busy = 1'b0;
  logic [3:0] busy_cnt = 4'd0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_viol = 0;
  logic [7:0] sent[$];
  int start_cyc[$];

  key_tx_queue #(.DEPTH(16), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .keyValid(keyValid), .keyData(keyData),
    .keyIsSpecial(keyIsSpecial), .txStart(txStart), .txData(txData),
    .txBusy(txBusy), .fifoLevel(fifoLevel), .keyDropped(keyDropped),
    .dropCount(dropCount)
  );

  assign txBusy = force_hi | (model_en & model_busy);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy rises the edge after txStart is seen and stays high 10 cycles.
  always @(posedge clk) begin
    if (model_en && txStart) begin
      model_busy <= 1'b1;
      busy_cnt   <= 4'd10;
    end else if (busy_cnt != 4'd0) begin
      busy_cnt <= busy_cnt - 4'd1;
      if (busy_cnt == 4'd1) model_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (txStart) begin
      sent.push_back(txData);
      start_cyc.push_back(cyc);
      if (txBusy) busy_viol++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sent_at(input int i);
    return (i < sent.size()) ? sent[i] : 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_key(input logic [7:0] d, input logic sp);
    keyData = d;
    keyIsSpecial = sp;
    keyValid = 1'b1;
    @(negedge clk);
    keyValid = 1'b0;
    keyIsSpecial = 1'b0;
  endtask

  task automatic drain(input int budget);
    int stable = 0;
    int i = 0;
    while (stable < 8 && i < budget) begin
      @(negedge clk);
      i++;
      if (fifoLevel == 5'd0 && !txBusy && !txStart) stable++;
      else stable = 0;
    end
    n_checks++;
    if (stable < 8) begin
      n_fail++;
      $display("FAIL drain_timeout: level=%0d busy=%0b after %0d cycles, required empty/idle", fifoLevel, txBusy, i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++; if (txStart !== 1'b0)    begin n_fail++; $display("FAIL reset_txStart: got %b exp 0", txStart); end
    n_checks++; if (txData !== 8'h00)    begin n_fail++; $display("FAIL reset_txData: got %h exp 00", txData); end
    n_checks++; if (fifoLevel !== 5'd0)  begin n_fail++; $display("FAIL reset_level: got %0d exp 0", fifoLevel); end
    n_checks++; if (keyDropped !== 1'b0) begin n_fail++; $display("FAIL reset_keyDropped: got %b exp 0", keyDropped); end
    n_checks++; if (dropCount !== 8'h00) begin n_fail++; $display("FAIL reset_dropCount: got %0d exp 0", dropCount); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_key();
    model_en = 1'b1;
    sent.delete();
    push_key(8'h61, 1'b0);
    n_checks++; if (fifoLevel !== 5'd1) begin n_fail++; $display("FAIL single_level_after_push: got %0d exp 1", fifoLevel); end
    n_checks++; if (txStart !== 1'b0)   begin n_fail++; $display("FAIL single_no_early_start: got %b exp 0", txStart); end
    tick(1);
    n_checks++; if (txStart !== 1'b1)   begin n_fail++; $display("FAIL single_start_latency: got %b exp 1", txStart); end
    n_checks++; if (txData !== 8'h61)   begin n_fail++; $display("FAIL single_txData: got %h exp 61", txData); end
    n_checks++; if (fifoLevel !== 5'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d exp 0", fifoLevel); end
    drain(200);
    n_checks++; if (sent.size() !== 1)  begin n_fail++; $display("FAIL single_count: got %0d exp 1", sent.size()); end
  endtask

  task automatic test_escape();
    logic [7:0] exp [3] = '{8'h1B, 8'h5B, 8'h41};
    sent.delete();
    busy_viol = 0;
    push_key(8'h01, 1'b1);
    n_checks++; if (fifoLevel !== 5'd3) begin n_fail++; $display("FAIL esc_level: got %0d exp 3", fifoLevel); end
    drain(300);
    n_checks++; if (sent.size() !== 3)  begin n_fail++; $display("FAIL esc_count: got %0d exp 3", sent.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (sent_at(i) !== exp[i]) begin n_fail++; $display("FAIL esc_byte%0d: got %h exp %h", i, sent_at(i), exp[i]); end
    end
    n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL esc_start_while_busy: got %0d exp 0", busy_viol); end
  endtask

  task automatic test_back_to_back();
    sent.delete();
    push_key(8'h62, 1'b0);
    push_key(8'h63, 1'b0);
    n_checks++; if (fifoLevel !== 5'd1) begin n_fail++; $display("FAIL b2b_push_pop_level: got %0d exp 1", fifoLevel); end
    drain(300);
    n_checks++; if (sent_at(0) !== 8'h62 || sent_at(1) !== 8'h63 || sent.size() !== 2)
      begin n_fail++; $display("FAIL b2b_order: got %h %h (n=%0d) exp 62 63", sent_at(0), sent_at(1), sent.size()); end
  endtask

  task automatic test_full_drop();
    model_en = 1'b0;
    force_hi = 1'b1;
    for (int i = 0; i < 16; i++) push_key(8'h30 + 8'(i), 1'b0);
    n_checks++; if (fifoLevel !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d exp 16", fifoLevel); end
    n_checks++; if (keyDropped !== 1'b0) begin n_fail++; $display("FAIL full_no_drop_yet: got %b exp 0", keyDropped); end
    push_key(8'h7A, 1'b0);
    n_checks++; if (keyDropped !== 1'b1) begin n_fail++; $display("FAIL full_drop_pulse: got %b exp 1", keyDropped); end
    n_checks++; if (dropCount !== 8'd1)  begin n_fail++; $display("FAIL full_dropCount1: got %0d exp 1", dropCount); end
    n_checks++; if (fifoLevel !== 5'd16) begin n_fail++; $display("FAIL full_level_kept: got %0d exp 16", fifoLevel); end
    tick(1);
    n_checks++; if (keyDropped !== 1'b0) begin n_fail++; $display("FAIL full_drop_one_cycle: got %b exp 0", keyDropped); end
    push_key(8'h02, 1'b1);
    n_checks++; if (keyDropped !== 1'b1) begin n_fail++; $display("FAIL full_special_drop: got %b exp 1", keyDropped); end
    n_checks++; if (dropCount !== 8'd2)  begin n_fail++; $display("FAIL full_dropCount2: got %0d exp 2", dropCount); end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_checks++; if (fifoLevel !== 5'd0 || dropCount !== 8'd0)
      begin n_fail++; $display("FAIL full_reset_clears: level=%0d drops=%0d exp 0 0", fifoLevel, dropCount); end
  endtask

  task automatic test_partial_fit();
    force_hi = 1'b1;
    sent.delete();
    for (int i = 0; i < 14; i++) push_key(8'h40 + 8'(i), 1'b0);
    n_checks++; if (fifoLevel !== 5'd14) begin n_fail++; $display("FAIL part_level14: got %0d exp 14", fifoLevel); end
    push_key(8'h03, 1'b1);
    n_checks++; if (keyDropped !== 1'b1) begin n_fail++; $display("FAIL part_reject_pulse: got %b exp 1", keyDropped); end
    n_checks++; if (fifoLevel !== 5'd14) begin n_fail++; $display("FAIL part_reject_level: got %0d exp 14", fifoLevel); end
    force_hi = 1'b0;
    model_en = 1'b1;
    tick(1);
    n_checks++; if (fifoLevel !== 5'd13) begin n_fail++; $display("FAIL part_one_pop: got %0d exp 13", fifoLevel); end
    force_hi = 1'b1;
    push_key(8'h03, 1'b1);
    n_checks++; if (fifoLevel !== 5'd16) begin n_fail++; $display("FAIL part_accept_level: got %0d exp 16", fifoLevel); end
    n_checks++; if (keyDropped !== 1'b0) begin n_fail++; $display("FAIL part_accept_no_drop: got %b exp 0", keyDropped); end
    force_hi = 1'b0;
    drain(800);
    n_checks++; if (sent.size() !== 17) begin n_fail++; $display("FAIL part_count: got %0d exp 17", sent.size()); end
    for (int i = 0; i < 14; i++) begin
      n_checks++;
      if (sent_at(i) !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL part_byte%0d: got %h exp %h", i, sent_at(i), 8'h40 + 8'(i)); end
    end
    n_checks++; if (sent_at(14) !== 8'h1B || sent_at(15) !== 8'h5B || sent_at(16) !== 8'h43)
      begin n_fail++; $display("FAIL part_tail: got %h %h %h exp 1b 5b 43", sent_at(14), sent_at(15), sent_at(16)); end
  endtask

  task automatic test_timeout_and_reset();
    int w = 0;
    model_en = 1'b0;
    force_hi = 1'b0;
    sent.delete();
    start_cyc.delete();
    push_key(8'h78, 1'b0);
    push_key(8'h79, 1'b0);
    drain(200);
    n_checks++; if (sent_at(0) !== 8'h78 || sent_at(1) !== 8'h79 || sent.size() !== 2)
      begin n_fail++; $display("FAIL to_bytes: got %h %h (n=%0d) exp 78 79", sent_at(0), sent_at(1), sent.size()); end
    n_checks++;
    if (start_cyc.size() != 2 || (start_cyc[1] - start_cyc[0]) !== 6) begin
      n_fail++;
      $display("FAIL to_spacing: got %0d exp 6", (start_cyc.size() == 2) ? start_cyc[1] - start_cyc[0] : -1);
    end
    model_en = 1'b1;
    push_key(8'h70, 1'b0);
    push_key(8'h71, 1'b0);
    while (!txStart && w < 20) begin @(negedge clk); w++; end
    n_checks++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_start: got %b exp 1", txStart); end
    tick(2);
    rst = 1'b1;
    tick(1);
    n_checks++; if (txStart !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_txStart: got %b exp 0", txStart); end
    n_checks++; if (fifoLevel !== 5'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d exp 0", fifoLevel); end
    n_checks++; if (txData !== 8'h00)   begin n_fail++; $display("FAIL rst_mid_txData: got %h exp 00", txData); end
    rst = 1'b0;
    sent.delete();
    tick(30);
    n_checks++; if (sent.size() !== 0) begin n_fail++; $display("FAIL rst_mid_idle: got %0d starts exp 0", sent.size()); end
  endtask

  task automatic test_newline_and_ignored();
    model_en = 1'b1;
    sent.delete();
    push_key(8'h0D, 1'b0);
`ifdef NEWLINE_CRLF_EN
    n_checks++; if (fifoLevel !== 5'd2) begin n_fail++; $display("FAIL cr_level: got %0d exp 2", fifoLevel); end
    drain(300);
    n_checks++; if (sent_at(0) !== 8'h0D || sent_at(1) !== 8'h0A || sent.size() !== 2)
      begin n_fail++; $display("FAIL cr_bytes: got %h %h (n=%0d) exp 0d 0a", sent_at(0), sent_at(1), sent.size()); end
`else
    n_checks++; if (fifoLevel !== 5'd1) begin n_fail++; $display("FAIL cr_level: got %0d exp 1", fifoLevel); end
    drain(300);
    n_checks++; if (sent_at(0) !== 8'h0D || sent.size() !== 1)
      begin n_fail++; $display("FAIL cr_bytes: got %h (n=%0d) exp 0d n=1", sent_at(0), sent.size()); end
`endif
    sent.delete();
    push_key(8'h09, 1'b1);
    n_checks++; if (keyDropped !== 1'b0) begin n_fail++; $display("FAIL ign_drop: got %b exp 0", keyDropped); end
    n_checks++; if (fifoLevel !== 5'd0)  begin n_fail++; $display("FAIL ign_level: got %0d exp 0", fifoLevel); end
    n_checks++; if (dropCount !== 8'd0)  begin n_fail++; $display("FAIL ign_dropCount: got %0d exp 0", dropCount); end
    tick(5);
    n_checks++; if (sent.size() !== 0)   begin n_fail++; $display("FAIL ign_no_tx: got %0d exp 0", sent.size()); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_escape();
    test_back_to_back();
    test_full_drop();
    test_partial_fit();
    test_timeout_and_reset();
    test_newline_and_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
